// File: rtl/sha256_job_arbiter.sv
// Round-robin arbiter sharing one single-block SHA-256 core among N_REQ requesters.
// Define SHA_ARB_WATCHDOG_EN to build the WAIT-state timeout that answers with resp_error.
module sha256_job_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*512-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [255:0]         resp_hash,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_error,
  output logic                 busy,
  output logic                 core_rst,
  output logic                 core_ena,
  output logic [511:0]         core_data,
  output logic                 core_valid,
  input  logic [255:0]         core_hash,
  input  logic                 core_hash_valid
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    CLEAR
  } state_t;

  state_t          state, state_nx;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] job_id;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] scan;
  logic            pick_ok;
  logic            timeout;

  // First valid requester strictly after the previous grant, wrapping.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    scan    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan = ID_W'((int'(last_grant) + k) % N_REQ);
      if (!pick_ok && req_valid[scan]) begin
        pick    = scan;
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    core_valid = 1'b0;
    core_ena   = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          req_ready[pick] = 1'b1;
          state_nx        = LAUNCH;
        end
      end
      LAUNCH: begin
        core_ena   = 1'b1;
        core_valid = 1'b1;
        state_nx   = WAIT;
      end
      WAIT: begin
        core_ena = 1'b1;
        if (core_hash_valid || timeout)
          state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_nx = CLEAR;
      end
      CLEAR: begin
        core_ena = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign core_rst = rst | (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      job_id     <= '0;
      core_data  <= '0;
      resp_hash  <= '0;
      resp_id    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_ok) begin
        core_data  <= req_data[int'(pick)*512 +: 512];
        job_id     <= pick;
        last_grant <= pick;
      end
      if (state == WAIT) begin
        if (core_hash_valid) begin
          resp_hash <= core_hash;
          resp_id   <= job_id;
        end else if (timeout) begin
          resp_hash <= '0;
          resp_id   <= job_id;
        end
      end
    end
  end

`ifdef SHA_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle without a digest.
  assign timeout = (state == WAIT) && !core_hash_valid &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == LAUNCH)
        wd_cnt <= '0;
      else if (state == WAIT)
        wd_cnt <= wd_cnt + 1'b1;
      if (state == WAIT && core_hash_valid)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
    end
  end

  assign resp_error = err_q;
`else
  // Without the watchdog the limit is meaningless; WAIT never times out.
  assign timeout    = (TIMEOUT_CYCLES < 0);
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Directed bench for sha256_job_arbiter with a latency-programmable core stub.
// Covers reset, single job, round-robin, idle skip, backpressure, mid-job reset, watchdog.
module tb_sha256_job_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h18};
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*512-1:0] req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [255:0]     resp_hash;
  logic [IW-1:0]    resp_id;
  logic             resp_error;
  logic             busy;
  logic             core_rst;
  logic             core_ena;
  logic [511:0]     core_data;
  logic             core_valid;
  logic [255:0]     core_hash;
  logic             core_hash_valid;

  always #5 clk = ~clk;

  sha256_job_arbiter #(
    .N_REQ(N),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_hash(resp_hash),
    .resp_id(resp_id),
    .resp_error(resp_error),
    .busy(busy),
    .core_rst(core_rst),
    .core_ena(core_ena),
    .core_data(core_data),
    .core_valid(core_valid),
    .core_hash(core_hash),
    .core_hash_valid(core_hash_valid)
  );

  function automatic logic [255:0] stub_hash(input logic [511:0] b);
    return (b == ABC_BLK) ? ABC_HASH : (b[511:256] ^ b[255:0]);
  endfunction

  // Core stub: digest after stub_lat cycles, held until core_rst.
  int           stub_lat;
  bit           stub_never;
  int           stub_cnt;
  bit           stub_run;
  logic [511:0] stub_blk;
  logic         stub_hv;
  logic [255:0] stub_h;
  logic         inj_hv;
  logic [255:0] inj_h;

  always @(posedge clk) begin
    if (core_rst) begin
      stub_hv  <= 1'b0;
      stub_run <= 1'b0;
      stub_h   <= '0;
    end else if (core_ena && core_valid) begin
      stub_blk <= core_data;
      stub_run <= 1'b1;
      stub_cnt <= stub_lat;
    end else if (stub_run && !stub_hv && !stub_never) begin
      if (stub_cnt <= 1) begin
        stub_hv <= 1'b1;
        stub_h  <= stub_hash(stub_blk);
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  assign core_hash_valid = stub_hv | inj_hv;
  assign core_hash       = inj_hv ? inj_h : stub_h;

  // Event monitor, sampled at the active edge before state updates.
  int           n_rr, n_cv, n_cr, n_multi;
  int           rids[$];
  logic [255:0] rhash[$];

  initial begin
    n_rr = 0; n_cv = 0; n_cr = 0; n_multi = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (|req_ready) begin
        n_rr++;
        if ($countones(req_ready) != 1) n_multi++;
      end
      if (core_valid) n_cv++;
      if (core_rst) n_cr++;
      if (resp_valid && resp_ready) begin
        rids.push_back(int'(resp_id));
        rhash.push_back(resp_hash);
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_resp(input int lim, output int waited);
    waited = 0;
    while (!resp_valid && waited < lim) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int w;
    w = 0;
    while (busy && w < lim) begin
      @(negedge clk);
      w++;
    end
    check(tag, w < lim, 1'b1);
  endtask

  task automatic wait_rids(input int want, input int lim, input string tag);
    int w;
    w = 0;
    while (rids.size() < want && w < lim) begin
      @(negedge clk);
      w++;
    end
    check(tag, w < lim, 1'b1);
  endtask

  function automatic int rid_at(input int i);
    return (i < rids.size()) ? rids[i] : -1;
  endfunction

  function automatic logic [255:0] rhash_at(input int i);
    return (i < rhash.size()) ? rhash[i] : '1;
  endfunction

  logic [511:0] blks[N];
  int           b_rr, b_cv, b_cr, b_multi, b_q;
  int           waited;
  int           bad;
  logic [255:0] h0;
  logic [IW-1:0] id0;

  task automatic mark();
    b_rr = n_rr; b_cv = n_cv; b_cr = n_cr;
    b_multi = n_multi; b_q = rids.size();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    inj_hv = 1'b0; inj_h = '0; stub_lat = 3; stub_never = 1'b0;
    for (int i = 0; i < N; i++) begin
      blks[i] = {256'(i + 1) * 256'h9E3779B97F4A7C15, 256'hDEADBEEF + 256'(i)};
      req_data[i*512 +: 512] = blks[i];
    end
    cyc(3);

    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_ena", core_ena, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_resp_hash", resp_hash, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_core_data", core_data, 0);
    rst = 1'b0;
    cyc(1);
    check("rst_core_rst_low", core_rst, 0);

    // Single job, requester 2, abc block
    mark();
    req_data[2*512 +: 512] = ABC_BLK;
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    check("abc_req_ready", req_ready, 4'b0100);
    cyc(1);
    req_valid = '0;
    check("abc_core_data", core_data, ABC_BLK);
    wait_idle(60, "abc_done");
    cyc(1);
    check("abc_n_ready", n_rr - b_rr, 1);
    check("abc_n_core_valid", n_cv - b_cv, 1);
    check("abc_n_core_rst", n_cr - b_cr, 1);
    check("abc_resp_id", rid_at(b_q), 2);
    check("abc_resp_hash", rhash_at(b_q), ABC_HASH);
    req_data[2*512 +: 512] = blks[2];

    // Round-robin with all requesters valid from reset
    rst = 1'b1;
    stub_lat = 10;
    req_valid = 4'b1111;
    cyc(2);
    mark();
    rst = 1'b0;
    wait_rids(b_q + 5, 300, "rr_responses");
    req_valid = '0;
    wait_idle(40, "rr_done");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_id%0d", i), rid_at(b_q + i), i % N);
      check($sformatf("rr_hash%0d", i), rhash_at(b_q + i), stub_hash(blks[i % N]));
    end
    check("rr_onehot", n_multi - b_multi, 0);

    // Idle requesters skipped: grant 1 first, then 1 and 3 compete
    rst = 1'b1;
    stub_lat = 3;
    cyc(2);
    rst = 1'b0;
    req_valid = 4'b0010;
    cyc(1);
    req_valid = '0;
    wait_idle(40, "skip_first_done");
    mark();
    req_valid = 4'b1010;
    wait_rids(b_q + 2, 100, "skip_responses");
    req_valid = '0;
    wait_idle(40, "skip_done");
    check("skip_id0", rid_at(b_q), 3);
    check("skip_id1", rid_at(b_q + 1), 1);

    // Backpressure on the response
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    cyc(1);
    req_valid = '0;
    wait_resp(50, waited);
    check("bp_resp_seen", waited < 50, 1'b1);
    h0 = resp_hash;
    id0 = resp_id;
    check("bp_id", id0, 0);
    check("bp_hash", h0, stub_hash(blks[0]));
    mark();
    req_valid = 4'b0010;
    bad = 0;
    repeat (20) begin
      cyc(1);
      if (resp_hash !== h0 || resp_id !== id0 || resp_valid !== 1'b1) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_no_ready", n_rr - b_rr, 0);
    check("bp_no_core_valid", n_cv - b_cv, 0);
    check("bp_no_core_rst", n_cr - b_cr, 0);
    resp_ready = 1'b1;
    cyc(1);
    check("bp_clear_core_rst", core_rst, 1);
    check("bp_clear_resp_valid", resp_valid, 0);
    check("bp_clear_no_grant", req_ready, 0);
    cyc(1);
    check("bp_next_grant", req_ready, 4'b0010);
    cyc(1);
    req_valid = '0;
    wait_idle(40, "bp_done");

    // Reset five cycles into WAIT
    stub_never = 1'b1;
    req_valid = 4'b0100;
    cyc(1);
    req_valid = '0;
    check("mr_launch", core_valid, 1);
    cyc(5);
    check("mr_in_wait", busy, 1);
    rst = 1'b1;
    cyc(1);
    check("mr_busy", busy, 0);
    check("mr_resp_valid", resp_valid, 0);
    check("mr_core_rst", core_rst, 1);
    rst = 1'b0;
    stub_never = 1'b0;
    mark();
    inj_h = 256'hBAD0BAD;
    inj_hv = 1'b1;
    cyc(2);
    inj_hv = 1'b0;
    check("mr_ignore_busy", busy, 0);
    check("mr_ignore_resp_valid", resp_valid, 0);
    check("mr_ignore_hash", resp_hash, 0);
    check("mr_ignore_no_resp", rids.size() - b_q, 0);
    req_valid = 4'b1101;
    #1;
    check("mr_first_grant", req_ready, 4'b0001);
    cyc(1);
    req_valid = '0;
    wait_idle(40, "mr_done");

    // Core that never answers
    stub_never = 1'b1;
    req_valid = 4'b0100;
    cyc(1);
    req_valid = '0;
`ifdef SHA_ARB_WATCHDOG_EN
    wait_resp(40, waited);
    check("wd_latency", waited, 17);
    check("wd_error", resp_error, 1);
    check("wd_hash", resp_hash, 0);
    check("wd_id", resp_id, 2);
    cyc(1);
    check("wd_clear", core_rst, 1);
    wait_idle(10, "wd_done");
`else
    cyc(40);
    check("nowd_busy", busy, 1);
    check("nowd_resp_valid", resp_valid, 0);
    check("nowd_error", resp_error, 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
`endif
    stub_never = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
